// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle between the fetch unit, instruction memory
// and the decode stage.
//   imem_req/imem_addr     fetch request and word-aligned byte address
//   imem_ready             memory accepts the request this cycle
//   imem_rvalid/imem_rdata response strobe and instruction word
//   instr_valid/instr/instr_pc  fetched instruction offered to decode
//   instr_ready            decode consumes the instruction this cycle
// modport master: fetch unit side. modport slave: memory + decode side.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I front end. Owns the PC, issues one word fetch at a
// time over a req/ready + rvalid handshake, and offers each instruction with
// its PC to decode over valid/ready. Branch/JAL redirects from execute flush
// the offered instruction and discard any stale in-flight response.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   bus             instr_fetch_unit_if.master (imem_* and instr_* signals)
//   redirect_valid  one-cycle redirect pulse
//   redirect_pc     redirect target
//   fetch_misaligned  (only with FETCH_MISALIGN_CHECK_EN) sticky flag set by
//                   a misaligned redirect; fetching stalls until an aligned
//                   redirect clears it
// Build option: define FETCH_MISALIGN_CHECK_EN to enable misaligned-redirect
// detection; otherwise redirect_pc[1:0] is forced to zero.
module instr_fetch_unit #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.master    bus,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic                fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            drop_q, drop_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic            fetch_stall;
  logic            accept;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    redir_tgt   = redirect_pc;
    redir_bad   = |redirect_pc[1:0];
    fetch_stall = misaligned_q;
`else
    redir_tgt   = redirect_pc & ~XLEN'(3);
    redir_bad   = 1'b0;
    fetch_stall = 1'b0;
`endif
  end

  // Request is gated by rst so nothing is issued while reset is held.
  assign bus.imem_req    = rst && (state_q == ST_REQ) && !fetch_stall;
  assign bus.imem_addr   = pc_q;
  assign accept          = bus.imem_req && bus.imem_ready;

  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    misaligned_d  = misaligned_q;

    unique case (state_q)
      ST_REQ: begin
        if (accept) begin
          fetch_pc_d = pc_q;
          state_d    = ST_WAIT;
          // The old address was already accepted; its response is stale.
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
            pc_d          = fetch_pc_q + XLEN'(4);
            state_d       = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides any pc/valid update chosen above.
    if (redirect_valid) begin
      pc_d          = redir_tgt;
      instr_valid_d = 1'b0;
      misaligned_d  = redir_bad;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misaligned = misaligned_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned_q ^ misaligned_d ^ redir_bad;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk;
  logic        rst;
  logic        redir0_valid, redir1_valid;
  logic [31:0] redir0_pc, redir1_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misal0, misal1;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  instr_fetch_unit_if #(.XLEN(32)) bus0 ();
  instr_fetch_unit_if #(.XLEN(32)) bus1 ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus0),
    .redirect_valid (redir0_valid),
    .redirect_pc    (redir0_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned (misal0)
`endif
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus1),
    .redirect_valid (redir1_valid),
    .redirect_pc    (redir1_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned (misal1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch on dut0 with a 1-cycle memory, consumed immediately.
  task automatic fetch0(input logic [31:0] a, input logic [31:0] d);
    check("f_req", bus0.imem_req, 32'd1);
    check("f_addr", bus0.imem_addr, a);
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    check("f_wait_valid", bus0.instr_valid, 32'd0);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = d;
    step();
    bus0.imem_rvalid = 1'b0;
    check("f_valid", bus0.instr_valid, 32'd1);
    check("f_instr", bus0.instr, d);
    check("f_pc", bus0.instr_pc, a);
    bus0.instr_ready = 1'b1;
    step();
    bus0.instr_ready = 1'b0;
    check("f_done_valid", bus0.instr_valid, 32'd0);
    check("f_next_addr", bus0.imem_addr, a + 32'd4);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    redir0_valid = 1'b0; redir0_pc = '0;
    redir1_valid = 1'b0; redir1_pc = '0;
    bus0.imem_ready = 1'b0; bus0.imem_rvalid = 1'b0; bus0.imem_rdata = '0; bus0.instr_ready = 1'b0;
    bus1.imem_ready = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = '0; bus1.instr_ready = 1'b0;
    step();
    step();

    // Reset values
    check("rst_req", bus0.imem_req, 32'd0);
    check("rst_addr", bus0.imem_addr, 32'h0);
    check("rst_valid", bus0.instr_valid, 32'd0);
    check("rst_instr", bus0.instr, 32'h0);
    check("rst_instr_pc", bus0.instr_pc, 32'h0);
    check("rst_addr1", bus1.imem_addr, 32'hFFFF_FFFC);

    rst = 1'b1;
    #1;
    check("rel_req", bus0.imem_req, 32'd1);
    check("rel_addr", bus0.imem_addr, 32'h0);

    // First fetch at 0, decode stalls 5 cycles
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    check("w0_req", bus0.imem_req, 32'd0);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'h0000_0013;
    step();
    bus0.imem_rvalid = 1'b0;
    check("i0_valid", bus0.instr_valid, 32'd1);
    check("i0_instr", bus0.instr, 32'h0000_0013);
    check("i0_pc", bus0.instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", bus0.instr_valid, 32'd1);
      check("hold_instr", bus0.instr, 32'h0000_0013);
      check("hold_pc", bus0.instr_pc, 32'h0);
      check("hold_req", bus0.imem_req, 32'd0);
    end
    bus0.instr_ready = 1'b1;
    step();
    bus0.instr_ready = 1'b0;
    check("rel_valid", bus0.instr_valid, 32'd0);
    check("next_req", bus0.imem_req, 32'd1);
    check("next_addr", bus0.imem_addr, 32'h4);

    fetch0(32'h4, 32'h0040_0093);

    // Redirect to 0x100 while waiting on addr 8
    check("w8_addr", bus0.imem_addr, 32'h8);
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    redir0_valid = 1'b1; redir0_pc = 32'h100;
    step();
    redir0_valid = 1'b0;
    check("rw_req", bus0.imem_req, 32'd0);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus0.imem_rvalid = 1'b0;
    check("rw_drop_valid", bus0.instr_valid, 32'd0);
    check("rw_req2", bus0.imem_req, 32'd1);
    check("rw_addr", bus0.imem_addr, 32'h100);
    fetch0(32'h100, 32'h0000_0093);

    // Redirect to 0x200 coincident with acceptance of 0x104
    check("ra_addr", bus0.imem_addr, 32'h104);
    bus0.imem_ready = 1'b1;
    redir0_valid = 1'b1; redir0_pc = 32'h200;
    step();
    bus0.imem_ready = 1'b0;
    redir0_valid = 1'b0;
    check("ra_req", bus0.imem_req, 32'd0);
    check("ra_addr_new", bus0.imem_addr, 32'h200);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'hBAD0_0104;
    step();
    bus0.imem_rvalid = 1'b0;
    check("ra_drop_valid", bus0.instr_valid, 32'd0);
    check("ra_req2", bus0.imem_req, 32'd1);
    check("ra_addr2", bus0.imem_addr, 32'h200);
    fetch0(32'h200, 32'h0010_0113);

    // Redirect in HOLD with simultaneous instr_ready
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'h0020_0193;
    step();
    bus0.imem_rvalid = 1'b0;
    check("rh_valid", bus0.instr_valid, 32'd1);
    check("rh_pc", bus0.instr_pc, 32'h204);
    redir0_valid = 1'b1; redir0_pc = 32'h300;
    bus0.instr_ready = 1'b1;
    step();
    redir0_valid = 1'b0;
    bus0.instr_ready = 1'b0;
    check("rh_flush", bus0.instr_valid, 32'd0);
    check("rh_req", bus0.imem_req, 32'd1);
    check("rh_addr", bus0.imem_addr, 32'h300);

    // Redirect in REQ without ready, then stray rvalid in REQ
    redir0_valid = 1'b1; redir0_pc = 32'h400;
    step();
    redir0_valid = 1'b0;
    check("rr_addr", bus0.imem_addr, 32'h400);
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'h1234_5678;
    step();
    bus0.imem_rvalid = 1'b0;
    check("stray_valid", bus0.instr_valid, 32'd0);
    check("stray_req", bus0.imem_req, 32'd1);
    check("stray_addr", bus0.imem_addr, 32'h400);

    // Redirect in WAIT together with rvalid: data discarded, back to REQ
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'hCAFE_0400;
    redir0_valid = 1'b1; redir0_pc = 32'h500;
    step();
    bus0.imem_rvalid = 1'b0;
    redir0_valid = 1'b0;
    check("wr_valid", bus0.instr_valid, 32'd0);
    check("wr_req", bus0.imem_req, 32'd1);
    check("wr_addr", bus0.imem_addr, 32'h500);

    // Misaligned redirect target
    redir0_valid = 1'b1; redir0_pc = 32'h102;
    step();
    redir0_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_flag", misal0, 32'd1);
    check("mis_req", bus0.imem_req, 32'd0);
    check("mis_addr", bus0.imem_addr, 32'h102);
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    check("mis_stall_req", bus0.imem_req, 32'd0);
    check("mis_stall_flag", misal0, 32'd1);
    redir0_valid = 1'b1; redir0_pc = 32'h104;
    step();
    redir0_valid = 1'b0;
    check("mis_clr_flag", misal0, 32'd0);
    check("mis_clr_req", bus0.imem_req, 32'd1);
    check("mis_clr_addr", bus0.imem_addr, 32'h104);
`else
    check("align_req", bus0.imem_req, 32'd1);
    check("align_addr", bus0.imem_addr, 32'h100);
`endif

    // Asynchronous reset mid-request, then stray response after release
    bus0.imem_ready = 1'b1;
    step();
    bus0.imem_ready = 1'b0;
    check("mr_wait_req", bus0.imem_req, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mr_req", bus0.imem_req, 32'd0);
    check("mr_addr", bus0.imem_addr, 32'h0);
    check("mr_valid", bus0.instr_valid, 32'd0);
    check("mr_pc", bus0.instr_pc, 32'h0);
    step();
    rst = 1'b1;
    bus0.imem_rvalid = 1'b1;
    bus0.imem_rdata  = 32'hFACE_FEED;
    step();
    bus0.imem_rvalid = 1'b0;
    check("mr_stray_valid", bus0.instr_valid, 32'd0);
    check("mr_stray_req", bus0.imem_req, 32'd1);
    check("mr_stray_addr", bus0.imem_addr, 32'h0);

    // PC wrap on dut1 (RESET_PC = 0xFFFF_FFFC)
    check("wrap_req", bus1.imem_req, 32'd1);
    check("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_ready = 1'b1;
    step();
    bus1.imem_ready = 1'b0;
    bus1.imem_rvalid = 1'b1;
    bus1.imem_rdata  = 32'h0000_006F;
    step();
    bus1.imem_rvalid = 1'b0;
    check("wrap_valid", bus1.instr_valid, 32'd1);
    check("wrap_instr", bus1.instr, 32'h0000_006F);
    check("wrap_pc", bus1.instr_pc, 32'hFFFF_FFFC);
    bus1.instr_ready = 1'b1;
    step();
    bus1.instr_ready = 1'b0;
    check("wrap_next_req", bus1.imem_req, 32'd1);
    check("wrap_next_addr", bus1.imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream front-end stage of the RV32I core. Owns the program counter and issues word fetches to instruction memory over a req/ready + rvalid handshake.
- Presents each fetched instruction with its PC to the decode stage over a valid/ready handshake; decode feeds instr[6:0] to the opcode type decoder.
- Accepts branch/JAL redirects from execute and discards any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  XLEN  fetch byte address, word-aligned
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response valid
- imem_rdata  input  XLEN  fetched instruction word
- instr_valid  output  1  instr/instr_pc valid to decode
- instr  output  XLEN  instruction word
- instr_pc  output  XLEN  PC of instr
- instr_ready  input  1  decode consumes instr this cycle
- redirect_valid  input  1  branch taken / JAL, one-cycle pulse
- redirect_pc  input  XLEN  redirect target

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values (rst low): pc=RESET_PC, state=REQ, drop=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- imem_req is combinational from state: 1 only in REQ and only while rst is high. imem_addr=pc.
- Memory protocol: request handshake completes when imem_req&&imem_ready. The address may change while a request is not accepted. One outstanding request maximum. The response arrives 1 or more cycles after acceptance.
- State machine (3 states, registered):
  - REQ: if imem_ready, latch fetch_pc<=pc and go to WAIT; otherwise stay.
  - WAIT: on imem_rvalid:
    - drop=1: discard the data, clear drop, go to REQ.
    - drop=0: instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, pc<=fetch_pc+4, go to HOLD.
  - HOLD: instr_valid=1, outputs stable. On instr_ready, instr_valid<=0 and go to REQ.
- Latency: minimum 2 cycles from request acceptance to instr_valid, with rvalid in the cycle after acceptance. Peak throughput is 1 instruction per 3 cycles.
- Redirect (redirect_valid=1) has highest priority in every state:
  - pc<=redirect_pc and instr_valid<=0. This is a flush; a simultaneous instr_ready is ignored.
  - REQ without imem_ready: stay in REQ. The next request uses the new pc.
  - REQ with imem_ready the same cycle: the old address is accepted. Go to WAIT with drop<=1.
  - WAIT without rvalid: drop<=1, stay in WAIT.
  - WAIT with rvalid the same cycle: discard the data, go to REQ.
  - HOLD: go to REQ.
- A redirect in the cycle after a dropped response is handled normally.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00.
- imem_rvalid outside WAIT is ignored.
- Reset mid-operation: return to reset values immediately. A response arriving after reset release is ignored because state is REQ.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1. The unit loads pc<=redirect_pc, flushes as normal, and enters REQ with imem_req held 0.
  - The unit stalls until a later aligned redirect, which clears fetch_misaligned and resumes fetching.
- Undefined: the port is absent and the low bits are forced to zero as above.

Test Plan:
- Reset release, memory with 1-cycle latency returning 32'h00000013 at addr 0 -> imem_req=1 addr=0 in cycle 1; instr_valid=1, instr=32'h00000013, instr_pc=0 two cycles after acceptance; next request at addr 4.
- instr_ready held 0 for 5 cycles with instr_valid=1 -> instr/instr_pc stable, no imem_req; instr_ready=1 -> instr_valid=0 next cycle, request addr 4 the cycle after.
- Redirect to 32'h100 while in WAIT for addr 8 -> response for 8 discarded, instr_valid stays 0, next request addr 32'h100, instr_pc=32'h100.
- Redirect to 32'h200 coincident with imem_ready on addr 12 -> that response is dropped, then a request to 32'h200 is issued.
- RESET_PC=32'hFFFF_FFFC, fetch one instruction -> next imem_addr=0.
- With FETCH_MISALIGN_CHECK_EN: redirect to 32'h102 -> fetch_misaligned=1, imem_req=0; redirect to 32'h104 -> flag clears, request addr 32'h104.
